// File: rtl/iob_eth_tx.sv
// rtl/iob_eth_tx.sv - MII transmitter: preamble, SFD, frame, zero pad, CRC-32 FCS, inter-packet gap
module iob_eth_crc32_byte (
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);
    // Reflected CRC-32, one byte per call, LSB first
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ byte_in[i])
                crc_out = (crc_out >> 1) ^ 32'hEDB88320;
            else
                crc_out = crc_out >> 1;
        end
    end
endmodule

module iob_eth_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IPG_BYTES    = 12
) (
    input  logic        TX_CLK,
    input  logic        rst,
    input  logic        send,
    input  logic [10:0] nbytes,
    output logic        ready,
    output logic        done,
    output logic [10:0] addr,
    input  logic [7:0]  data,
    output logic        TX_EN,
    output logic [3:0]  TX_DATA
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IPG} state_t;

    localparam logic [11:0] PRE_LAST = 12'(2 * PREAMBLE_LEN - 1);
    localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
    localparam logic [11:0] MIN_LAST = 12'(MIN_FRAME - 1);
    // One cycle short so that the following IDLE acceptance cycle completes the gap
    localparam logic [11:0] IPG_LAST = 12'(2 * IPG_BYTES - 2);

    state_t      state;
    logic [11:0] cnt;
    logic        phase;
    logic [10:0] len;
    logic [3:0]  byte_hi;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [7:0]  crc_byte;
    logic [31:0] fcs;
    logic [11:0] len_ext;

    assign len_ext  = {1'b0, len};
    assign crc_byte = (state == DATA) ? data : 8'h00;
    assign fcs      = ~crc;

    iob_eth_crc32_byte u_crc (
        .crc_in  (crc),
        .byte_in (crc_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= 1'b0;
            len     <= '0;
            byte_hi <= '0;
            crc     <= 32'hFFFFFFFF;
            ready   <= 1'b1;
            done    <= 1'b0;
            addr    <= '0;
            TX_EN   <= 1'b0;
            TX_DATA <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    TX_EN   <= 1'b0;
                    TX_DATA <= '0;
                    addr    <= '0;
                    if (send) begin
                        len   <= nbytes;
                        ready <= 1'b0;
                        cnt   <= '0;
                        state <= PRE;
                    end
                end
                PRE: begin
                    TX_EN   <= 1'b1;
                    TX_DATA <= 4'h5;
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= SFD;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                SFD: begin
                    TX_EN   <= 1'b1;
                    TX_DATA <= cnt[0] ? 4'hD : 4'h5;
                    if (cnt[0]) begin
                        cnt   <= '0;
                        phase <= 1'b0;
                        if (len != '0)
                            state <= DATA;
                        else if (len_ext < MIN_LEN)
                            state <= PAD;
                        else
                            state <= FCS;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                DATA: begin
                    TX_EN <= 1'b1;
                    if (!phase) begin
                        // Capture the byte, fold it into the CRC and prefetch the next one
                        TX_DATA <= data[3:0];
                        byte_hi <= data[7:4];
                        crc     <= crc_next;
                        phase   <= 1'b1;
                        if (cnt + 12'd1 < len_ext)
                            addr <= addr + 11'd1;
                    end else begin
                        TX_DATA <= byte_hi;
                        phase   <= 1'b0;
                        if (cnt == len_ext - 12'd1) begin
                            if (len_ext < MIN_LEN) begin
                                cnt   <= cnt + 12'd1;
                                state <= PAD;
                            end else begin
                                cnt   <= '0;
                                state <= FCS;
                            end
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                end
                PAD: begin
                    TX_EN   <= 1'b1;
                    TX_DATA <= '0;
                    if (!phase) begin
                        crc   <= crc_next;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (cnt == MIN_LAST) begin
                            cnt   <= '0;
                            state <= FCS;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                end
                FCS: begin
                    TX_EN   <= 1'b1;
                    TX_DATA <= fcs[{cnt[2:0], 2'b00} +: 4];
                    if (cnt[2:0] == 3'd7) begin
                        cnt   <= '0;
                        state <= IPG;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                IPG: begin
                    TX_EN   <= 1'b0;
                    TX_DATA <= '0;
                    if (cnt == IPG_LAST) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        crc   <= 32'hFFFFFFFF;
                        addr  <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
